i2s_dma_sched: RTL
==================

// Module: i2s_dma_sched
// PURPOSE
//  Services the four DMA request/acknowledge pairs of the AHB I2S peripheral (din_l/din_r = TX, dout_l/dout_r = RX).
//  Moves one 32-bit sample per grant between a local sample RAM (four ring buffers) and the peripheral register map.
//  Arbitration is round-robin; the block is the bus master for the peripheral's sel/we/addr/wdata/rdata port.
//  It sits between the sample RAM and the peripheral, replacing software polling of the full flags.
// PARAMETERS
//  BUF_AW   8   ring-buffer address width per channel; depth = 2**BUF_AW words; RAM address width = BUF_AW+2
// PORTS
//  clk         in   1            system clock, same clock as the I2S peripheral
//  rstn        in   1            asynchronous active-low reset
//  enable      in   1            1 = arbitrate requests; 0 = finish current transfer, then stay in IDLE
//  dma_req     in   4            [0]=din_l_req [1]=din_r_req [2]=dout_l_req [3]=dout_r_req
//  dma_ack     out  4            one-cycle ack pulses, same bit order as dma_req
//  bus_sel     out  1            peripheral select
//  bus_we      out  1            peripheral write strobe
//  bus_addr    out  32           peripheral word address: 1 dout_l, 2 dout_r, 3 din_l, 4 din_r
//  bus_wdata   out  32           sample written to din_l/din_r
//  bus_rdata   in   32           combinational peripheral read data
//  mem_re      out  1            RAM read strobe; data is valid on mem_rdata one cycle later
//  mem_we      out  1            RAM write strobe
//  mem_addr    out  BUF_AW+2     {channel[1:0], ptr[channel]}
//  mem_wdata   out  32           RX sample to RAM
//  mem_rdata   in   32           TX sample from RAM
//  ptr_o       out  4*BUF_AW     current ring pointer per channel; channel c at [c*BUF_AW +: BUF_AW]
//  wrap_o      out  4            one-cycle pulse when that channel's pointer wraps to 0
//  busy        out  1            1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; ptr=0; mask=0; rr_last=3 (so channel 0 has first priority).
//  FSM states: IDLE, ARB, MRD, MDAT, BWR, BRD, MWR, ACK.
//  - IDLE: go to ARB when enable=1 and (dma_req & ~mask) != 0.
//  - ARB: grant g = first eligible channel after rr_last, modulo 4; register g; rr_last<=g. TX (g<2) -> MRD; RX (g>=2) -> BRD.
//  - MRD: mem_re=1, mem_addr={g,ptr[g]} -> MDAT.
//  - MDAT: capture mem_rdata into the data register -> BWR.
//  - BWR: bus_sel=1, bus_we=1, bus_addr=3+g, bus_wdata=data -> ACK.
//  - BRD: bus_sel=1, bus_we=0, bus_addr=1+(g-2); capture bus_rdata -> MWR.
//  - MWR: mem_we=1, mem_addr={g,ptr[g]}, mem_wdata=data -> ACK.
//  - ACK: dma_ack[g]=1; ptr[g]<=ptr[g]+1, wrapping 2**BUF_AW-1 -> 0 with wrap_o[g]=1 in the same cycle; mask[g]<=1.
//    Next state is ARB if enable=1 and another eligible request exists, else IDLE.
//  Latency, ARB to ACK inclusive: TX 5 cycles, RX 4 cycles.
//  Mask rule: the peripheral's req falls after ack, not necessarily in the same cycle.
//    mask[c] clears on the first cycle dma_req[c]=0. A masked channel is never granted, which prevents a double service.
//  Bus outputs (sel/we/addr/wdata) are 0 outside BWR/BRD; mem strobes are 0 outside MRD/MWR.
//  Simultaneous requests: strict round-robin; a channel waits at most three other transfers.
//  A request arriving during a transfer is considered at the next ARB.
//  enable falling mid-transfer: the current transfer completes, including ACK; then IDLE.
//  Pointers and mask are kept while disabled.
//  Reset mid-transfer: immediate return to reset values. No ack is issued, and the partial transfer is discarded.
//  Pointer arithmetic: BUF_AW-bit unsigned, natural wrap.
// STRUCTURE
//  Shared package i2s_pkg: channel index constants (CH_DIN_L=0 .. CH_DOUT_R=3), peripheral register addresses (1..4), FSM state encoding.
//  One sub-module, i2s_rr_arb4: 4-way round-robin priority picker (req, last) -> (grant index, valid); purely combinational.
//  The FSM, data register, pointers, mask and wrap logic stay in i2s_dma_sched.
// TESTING
//  1. After reset, enable=1, dma_req=0001, RAM[0x000]=0xA5A5_0001
//     -> bus write addr 3, data 0xA5A5_0001; dma_ack=0001 in cycle 5 after ARB; ptr0=1.
//  2. dma_req=1000, bus_rdata=0x1234_5678
//     -> mem_we to addr {3,0}=0x300 with data 0x1234_5678; dma_ack=1000 4 cycles after ARB.
//  3. dma_req=1111 held, each deasserted 1 cycle after its ack -> grant order 0,1,2,3,0.
//  4. ptr1 at 0xFF, one din_r transfer -> ptr1=0x00; wrap_o=0010 for exactly one cycle, coincident with the ack.
//  5. Hold dma_req[0]=1 for 3 cycles after ack -> no second grant of channel 0 until req has dropped and re-risen.
//  6. Drop enable during BWR -> transfer and ack complete, then IDLE.
//     Assert rstn=0 during MDAT -> no ack; all outputs 0 immediately.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S DMA scheduler: channel indices,
// peripheral register word addresses and the transfer FSM encoding.
package i2s_pkg;

  localparam int NUM_CH = 4;

  // Channel index = bit position in dma_req/dma_ack
  localparam logic [1:0] CH_DIN_L  = 2'd0;
  localparam logic [1:0] CH_DIN_R  = 2'd1;
  localparam logic [1:0] CH_DOUT_L = 2'd2;
  localparam logic [1:0] CH_DOUT_R = 2'd3;

  // Peripheral register word addresses
  localparam logic [31:0] REG_DOUT_L = 32'd1;
  localparam logic [31:0] REG_DOUT_R = 32'd2;
  localparam logic [31:0] REG_DIN_L  = 32'd3;
  localparam logic [31:0] REG_DIN_R  = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_MRD,
    S_MDAT,
    S_BWR,
    S_BRD,
    S_MWR,
    S_ACK
  } state_t;

  // TX channels push RAM samples into the peripheral's din registers
  function automatic logic is_tx(input logic [1:0] ch);
    return (ch == CH_DIN_L) || (ch == CH_DIN_R);
  endfunction

  // Peripheral register serviced by a channel
  function automatic logic [31:0] reg_addr(input logic [1:0] ch);
    logic [31:0] a;
    case (ch)
      CH_DIN_L:  a = REG_DIN_L;
      CH_DIN_R:  a = REG_DIN_R;
      CH_DOUT_L: a = REG_DOUT_L;
      default:   a = REG_DOUT_R;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/i2s_rr_arb4.sv
// Combinational 4-way round-robin picker: returns the first requesting
// channel strictly after 'last' (wrapping), so 'last' itself has lowest
// priority.
module i2s_rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] idx;

  // Scan last+1, last+2, last+3, last+4 (=last) and keep the first hit
  always_comb begin
    grant = last;
    valid = 1'b0;
    idx   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!valid && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_dma_sched.sv
// DMA scheduler for the I2S peripheral: round-robin grants over the four
// req/ack pairs, moving one 32-bit sample per grant between a per-channel
// ring buffer in the sample RAM and the peripheral register map.
module i2s_dma_sched
  import i2s_pkg::*;
#(
  parameter int BUF_AW = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [3:0]            dma_req,
  output logic [3:0]            dma_ack,
  output logic                  bus_sel,
  output logic                  bus_we,
  output logic [31:0]           bus_addr,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [BUF_AW+1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [4*BUF_AW-1:0]   ptr_o,
  output logic [3:0]            wrap_o,
  output logic                  busy
);

  localparam logic [BUF_AW-1:0] PTR_MAX = '1;

  state_t            state;
  logic [1:0]        gnt;
  logic [1:0]        rr_last;
  logic [3:0]        mask;
  logic [BUF_AW-1:0] ptr [NUM_CH];

  logic [3:0]        eligible;
  logic [1:0]        arb_grant;
  logic              arb_valid;

  // A masked channel has already been acked and waits for its req to drop
  assign eligible = dma_req & ~mask;
  assign busy     = (state != S_IDLE);

  i2s_rr_arb4 u_arb (
    .req   (eligible),
    .last  (rr_last),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ptr_o
      assign ptr_o[gi*BUF_AW +: BUF_AW] = ptr[gi];
    end
  endgenerate

  // Transfer FSM; all bus/memory/ack outputs are registered and are set on
  // the transition into the state that owns them, cleared everywhere else.
  // bus_wdata / mem_wdata double as the sample data register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      gnt       <= '0;
      rr_last   <= 2'd3;
      mask      <= '0;
      for (int c = 0; c < NUM_CH; c++) ptr[c] <= '0;
      dma_ack   <= '0;
      wrap_o    <= '0;
      bus_sel   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      dma_ack   <= '0;
      wrap_o    <= '0;
      bus_sel   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      // Mask bit releases once the peripheral has dropped its request
      mask      <= mask & dma_req;

      case (state)
        S_IDLE: begin
          if (enable && (eligible != 4'b0)) state <= S_ARB;
        end
        S_ARB: begin
          if (enable && arb_valid) begin
            gnt     <= arb_grant;
            rr_last <= arb_grant;
            if (is_tx(arb_grant)) begin
              state    <= S_MRD;
              mem_re   <= 1'b1;
              mem_addr <= {arb_grant, ptr[arb_grant]};
            end else begin
              state    <= S_BRD;
              bus_sel  <= 1'b1;
              bus_addr <= reg_addr(arb_grant);
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_MRD: begin
          state <= S_MDAT;
        end
        S_MDAT: begin
          state     <= S_BWR;
          bus_sel   <= 1'b1;
          bus_we    <= 1'b1;
          bus_addr  <= reg_addr(gnt);
          bus_wdata <= mem_rdata;
        end
        S_BRD: begin
          state     <= S_MWR;
          mem_we    <= 1'b1;
          mem_addr  <= {gnt, ptr[gnt]};
          mem_wdata <= bus_rdata;
        end
        S_BWR, S_MWR: begin
          state        <= S_ACK;
          dma_ack[gnt] <= 1'b1;
          mask[gnt]    <= 1'b1;
          ptr[gnt]     <= ptr[gnt] + 1'b1;
          if (ptr[gnt] == PTR_MAX) wrap_o[gnt] <= 1'b1;
        end
        S_ACK: begin
          if (enable && (eligible != 4'b0)) state <= S_ARB;
          else                              state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
